// File: rtl/set_sched_pkg.sv
// set_sched_pkg -- shared constants for the set_scheduler block.
//   ST_IDLE / ST_WAIT : FSM state encoding (1-bit, legacy-compatible constants)
//   DEPTH_DEF         : default command FIFO depth
//   DLY_W_DEF         : default delay field width
package set_sched_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int DEPTH_DEF = 4;
  localparam int DLY_W_DEF = 8;

endpackage

// File: rtl/set_scheduler_if.sv
// set_scheduler_if -- command channel into the scheduler.
//   cmd_valid : command present (producer)
//   cmd_ready : command accepted when high with cmd_valid (scheduler)
//   cmd_val   : value to drive
//   cmd_z     : release the output instead of driving it
//   cmd_dly   : wait cycles before the command is applied
interface set_scheduler_if
  import set_sched_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_val;
  logic             cmd_z;
  logic [DLY_W-1:0] cmd_dly;

  modport master (output cmd_valid, cmd_val, cmd_z, cmd_dly, input cmd_ready);
  modport slave  (input cmd_valid, cmd_val, cmd_z, cmd_dly, output cmd_ready);

endinterface

// File: rtl/set_sched_fifo.sv
// set_sched_fifo -- synchronous FIFO holding queued scheduler commands.
//   clk, rst : clock and synchronous active-high reset (pointers only)
//   flush    : empties the FIFO on the next edge
//   push/din : write when not full
//   pop/dout : head entry; pop advances when not empty
//   full/empty : occupancy flags, derived from the current pointers
module set_sched_fifo
  import set_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = 2 + DLY_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is data only; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/set_scheduler.sv
// set_scheduler -- queues {val, z, dly} commands and applies each one to a
// registered output after its programmed delay.
//   clk, rst : clock and synchronous active-high reset (rst beats flush)
//   flush    : discard queued and in-flight commands, outputs hold
//   cmd      : command channel (set_scheduler_if.slave)
//   out      : registered drive value
//   out_oe   : output enable, 0 means out is to be treated as released
//   done     : one-cycle pulse on the edge a command is applied
//   busy     : FIFO non-empty or FSM not idle
module set_scheduler
  import set_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  set_scheduler_if.slave    cmd,
  output logic              out,
  output logic              out_oe,
  output logic              done,
  output logic              busy
);

  localparam int FW = 2 + DLY_W;

  logic [FW-1:0]    fifo_din;
  logic [FW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic             head_val;
  logic             head_z;
  logic [DLY_W-1:0] head_dly;

  logic [0:0]       state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             val_q, val_d;
  logic             z_q, z_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;

  assign cmd.cmd_ready = !fifo_full && !flush && !rst;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign fifo_din      = {cmd.cmd_val, cmd.cmd_z, cmd.cmd_dly};
  assign {head_val, head_z, head_dly} = fifo_dout;

  // The cycle right after an application (done high) is a deliberate idle
  // bubble: the next command is not popped until done has dropped.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && !done_q && !flush;

  set_sched_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    z_d     = z_q;
    out_d   = out_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cnt_d   = head_dly;
          val_d   = head_val;
          z_d     = head_z;
          state_d = ST_WAIT;
        end
      end
      default: begin
        // Counter only decrements while non-zero, so the max delay never wraps.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_d   = val_q;
          oe_d    = !z_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      out_d   = out_q;
      oe_d    = oe_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  // Latched command payload; only meaningful while in WAIT.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    z_q   <= z_d;
  end

  assign out    = out_q;
  assign out_oe = oe_q;
  assign done   = done_q;
  assign busy   = !fifo_empty || (state_q != ST_IDLE);

endmodule
